// File: rtl/det_arb_pkg.sv
// Shared constants and entry packing for the detection event arbiter.
// Register map, CTRL/STATUS bit positions and FIFO entry field layout.
package det_arb_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_EVENT   = 2'd2;
  localparam logic [1:0] ADDR_CH_MASK = 2'd3;

  localparam int unsigned CTRL_ARM    = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH  = 2;

  localparam int unsigned STATUS_EMPTY    = 16;
  localparam int unsigned STATUS_FULL     = 17;
  localparam int unsigned STATUS_COALESCE = 18;

  localparam int unsigned CH_LSB     = 28;
  localparam int unsigned VALID_BIT  = 27;
  localparam int unsigned TS_FIELD_W = 24;

  function automatic logic [31:0] pack_entry(input logic [3:0] ch,
                                             input logic [TS_FIELD_W-1:0] ts);
    logic [31:0] w;
    w = '0;
    w[CH_LSB +: 4]       = ch;
    w[VALID_BIT]         = 1'b1;
    w[TS_FIELD_W-1:0]    = ts;
    return w;
  endfunction

endpackage

// File: rtl/det_event_fifo.sv
// Synchronous show-ahead FIFO for detection events with flush, count, full and empty.
// A push is accepted when full only if a pop frees the slot on the same edge.
module det_event_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: head_data is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/det_event_arbiter.sv
// Timestamps per-channel detection edges and serialises them round-robin into an event FIFO.
// Define DET_ARB_TIMESTAMP_EN to build the timestamp counter and per-channel timestamp holds.
module det_event_arbiter
  import det_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TS_WIDTH   = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] det_in,
  output logic              irq
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              arm_q, irq_en_q, coalesce_q;
  logic [NUM_CH-1:0] ch_mask_q;
  logic [NUM_CH-1:0] d1_q, d2_q, pending_q;
  logic [CH_W-1:0]   last_grant_q;

  logic              wr_en, rd_en, wr_ctrl, wr_status, wr_mask;
  logic              flush, disarm, pop;
  logic [NUM_CH-1:0] edge_det, grant_vec;
  logic              grant_found, grant, can_push, coalesce_hit;
  logic [CH_W-1:0]   grant_ch;
  logic [23:0]       entry_ts;
  logic [31:0]       rd_mux;

  logic [31:0]       fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  logic              unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign wr_ctrl   = wr_en & (address == ADDR_CTRL);
  assign wr_status = wr_en & (address == ADDR_STATUS);
  assign wr_mask   = wr_en & (address == ADDR_CH_MASK);
  assign flush     = wr_ctrl & writedata[CTRL_FLUSH];
  assign disarm    = wr_ctrl & arm_q & ~writedata[CTRL_ARM];
  assign pop       = rd_en & (address == ADDR_EVENT) & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ch_mask_q <= '1;
    end else begin
      if (wr_ctrl) begin
        arm_q    <= writedata[CTRL_ARM];
        irq_en_q <= writedata[CTRL_IRQ_EN];
      end
      if (wr_mask) ch_mask_q <= writedata[NUM_CH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= det_in;
      d2_q <= d1_q;
    end
  end

  assign edge_det = d1_q & ~d2_q & ch_mask_q & {NUM_CH{arm_q}};

  // Two passes: channels above last_grant first, then wrap around from channel 0.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!grant_found && pending_q[i] && (i > int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!grant_found && pending_q[i]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(i);
      end
    end
  end

  assign can_push = ~fifo_full | pop;
  assign grant    = grant_found & can_push & ~flush;

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      grant_vec[i] = grant & (grant_ch == CH_W'(i));
    end
  end

  assign coalesce_hit = |(edge_det & pending_q & ~grant_vec);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      coalesce_q   <= 1'b0;
    end else begin
      if (flush || disarm) begin
        pending_q <= '0;
      end else begin
        pending_q <= (pending_q & ~grant_vec) | edge_det;
      end
      if (grant) last_grant_q <= grant_ch;
      if (flush) begin
        coalesce_q <= 1'b0;
      end else if (coalesce_hit) begin
        coalesce_q <= 1'b1;
      end else if (wr_status && writedata[STATUS_COALESCE]) begin
        coalesce_q <= 1'b0;
      end
    end
  end

`ifdef DET_ARB_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_hold_q [NUM_CH];
  logic [TS_WIDTH-1:0] grant_ts;
  logic [NUM_CH-1:0]   ts_load;

  // A coalesced edge keeps the older timestamp; a re-edge on the granted channel reloads.
  assign ts_load = edge_det & (~pending_q | grant_vec);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else if (flush) begin
      ts_q <= '0;
    end else if (arm_q) begin
      ts_q <= ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) ts_hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (ts_load[i]) ts_hold_q[i] <= ts_q;
      end
    end
  end

  always_comb begin
    grant_ts = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_vec[i]) grant_ts = ts_hold_q[i];
    end
  end

  assign entry_ts = 24'(grant_ts);
`else
  assign entry_ts = '0;
`endif

  det_event_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (grant),
    .push_data (pack_entry(4'(grant_ch), entry_ts)),
    .pop       (pop),
    .flush     (flush),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL: begin
        rd_mux[CTRL_ARM]    = arm_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_mux[15:0]            = 16'(fifo_count);
        rd_mux[STATUS_EMPTY]    = fifo_empty;
        rd_mux[STATUS_FULL]     = fifo_full;
        rd_mux[STATUS_COALESCE] = coalesce_q;
      end
      ADDR_EVENT:   rd_mux = fifo_empty ? 32'h0 : fifo_head;
      default:      rd_mux[NUM_CH-1:0] = ch_mask_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd_en) readdata <= rd_mux;
      irq <= irq_en_q & ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_det_event_arbiter.sv
// Self-checking bench for det_event_arbiter: register tables, hand-built corner sequences
// and randomised rounds checked against an order/timestamp model of the event stream.
module tb_det_event_arbiter;
  import det_arb_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 16;
`ifdef DET_ARB_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] det_in;
  logic              irq;

  det_event_arbiter #(
    .NUM_CH     (NUM_CH),
    .TS_WIDTH   (24),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .det_in     (det_in),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int base     = 0;  // edge index at which the timestamp counter was last zeroed while armed
  int last_m   = NUM_CH - 1;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [3:0] det;
    logic [3:0] mask;
    bit         arm;
    int         n;
  } ev_vec_t;

  reg_vec_t    reset_tab [4];
  ev_vec_t     ev_tab    [6];
  logic [31:0] expq [$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    if (a == ADDR_CTRL && d[2]) base = cyc;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    tick(1);
    chipselect = 1'b0;
    read_n     = 1'b1;
    d          = readdata;
  endtask

  // det_in is high for exactly one cycle; k is the edge that first samples it.
  task automatic pulse(input logic [3:0] m, output int k);
    k      = cyc + 1;
    det_in = m;
    tick(1);
    det_in = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    last_m = NUM_CH - 1;
  endtask

  function automatic logic [31:0] exp_entry(input int ch, input int k);
    logic [31:0] w;
    w        = '0;
    w[31:28] = 4'(ch);
    w[27]    = 1'b1;
    if (TS_EN) w[23:0] = 24'(k - base);
    return w;
  endfunction

  function automatic logic [31:0] status_word(input int cnt, input bit full, input bit coal);
    logic [31:0] w;
    w        = '0;
    w[15:0]  = 16'(cnt);
    w[16]    = (cnt == 0);
    w[17]    = full;
    w[18]    = coal;
    return w;
  endfunction

  task automatic drain(input string name);
    logic [31:0] rd;
    while (expq.size() > 0) begin
      bus_read(ADDR_EVENT, rd);
      check(name, rd, expq.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  mask, det, eff;
    int          k, k1, k2, k3, n, new_last;

    reset_tab[0] = '{ADDR_CTRL,    32'h0000_0000};
    reset_tab[1] = '{ADDR_STATUS,  32'h0001_0000};
    reset_tab[2] = '{ADDR_EVENT,   32'h0000_0000};
    reset_tab[3] = '{ADDR_CH_MASK, 32'h0000_000F};

    ev_tab[0] = '{4'b0100, 4'b1011, 1'b1, 0};
    ev_tab[1] = '{4'b0001, 4'b1111, 1'b0, 0};
    ev_tab[2] = '{4'b1111, 4'b1011, 1'b1, 3};
    ev_tab[3] = '{4'b1000, 4'b1000, 1'b1, 1};
    ev_tab[4] = '{4'b0110, 4'b0000, 1'b1, 0};
    ev_tab[5] = '{4'b1111, 4'b1111, 1'b1, 4};

    address = '0; chipselect = 0; read_n = 1; write_n = 1; writedata = '0; det_in = '0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Reset state
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(reset_tab[i].addr, rd);
      check($sformatf("reset_reg%0d", i), rd, reset_tab[i].exp);
    end

    // Single event on channel 2 with irq latency
    bus_write(ADDR_CTRL, 32'h7);
    pulse(4'b0100, k);
    tick(2);
    check("irq_k2_low", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_k3_high", {31'b0, irq}, 32'h1);
    bus_read(ADDR_EVENT, rd);
    check("ch2_entry", rd, exp_entry(2, k));
    bus_read(ADDR_STATUS, rd);
    check("ch2_status_after", rd, status_word(0, 0, 0));
    check("ch2_irq_fall", {31'b0, irq}, 32'h0);

    // Simultaneous edges and round-robin fairness
    apply_reset();
    bus_write(ADDR_CTRL, 32'h7);
    pulse(4'b1011, k);
    tick(5);
    expq.push_back(exp_entry(0, k));
    expq.push_back(exp_entry(1, k));
    expq.push_back(exp_entry(3, k));
    drain("rr_013");
    pulse(4'b0010, k);
    tick(4);
    expq.push_back(exp_entry(1, k));
    drain("rr_1");
    pulse(4'b1001, k);
    tick(5);
    expq.push_back(exp_entry(3, k));
    expq.push_back(exp_entry(0, k));
    drain("rr_30");

    // FIFO full, held pending, coalescing and pop-frees-slot grant
    bus_write(ADDR_CTRL, 32'h7);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pulse(4'b0001, k);
      expq.push_back(exp_entry(0, k));
      tick(2);
    end
    pulse(4'b0010, k1);
    tick(2);
    pulse(4'b0001, k2);
    tick(2);
    pulse(4'b0001, k3);
    tick(3);
    bus_read(ADDR_STATUS, rd);
    check("full_status", rd, status_word(FIFO_DEPTH, 1, 1));
    bus_read(ADDR_EVENT, rd);
    check("full_first_pop", rd, expq.pop_front());
    expq.push_back(exp_entry(1, k1));
    expq.push_back(exp_entry(0, k2));
    bus_read(ADDR_STATUS, rd);
    check("full_refill", rd, status_word(FIFO_DEPTH, 1, 1));
    bus_write(ADDR_STATUS, 32'h0004_0000);
    bus_read(ADDR_STATUS, rd);
    check("coalesce_clear", rd, status_word(FIFO_DEPTH, 1, 0));
    drain("full_drain");
    bus_read(ADDR_EVENT, rd);
    check("full_drained_empty", rd, 32'h0);

    // Masked and disarmed edges
    for (int i = 0; i < 6; i++) begin
      bus_write(ADDR_CH_MASK, {28'h0, ev_tab[i].mask});
      bus_write(ADDR_CTRL, ev_tab[i].arm ? 32'h7 : 32'h6);
      pulse(ev_tab[i].det, k);
      tick(6);
      bus_read(ADDR_STATUS, rd);
      check($sformatf("mask_row%0d", i), rd, status_word(ev_tab[i].n, 0, 0));
    end
    bus_write(ADDR_CH_MASK, 32'hF);
    bus_write(ADDR_CTRL, 32'h7);
    bus_read(ADDR_EVENT, rd);
    check("empty_event_read", rd, 32'h0);
    check("empty_irq", {31'b0, irq}, 32'h0);

    // Flush colliding with a push, then timestamp restart
    for (int i = 0; i < 5; i++) begin
      pulse(4'b0001, k);
      tick(2);
    end
    tick(1);
    bus_read(ADDR_STATUS, rd);
    check("preflush_count", rd, status_word(5, 0, 0));
    pulse(4'b0001, k);
    tick(1);
    bus_write(ADDR_CTRL, 32'h7);
    pulse(4'b1000, k);
    tick(4);
    bus_read(ADDR_STATUS, rd);
    check("postflush_count", rd, status_word(1, 0, 0));
    bus_read(ADDR_EVENT, rd);
    check("postflush_ts", rd, exp_entry(3, k));

    // Asynchronous reset mid-burst
    pulse(4'b1111, k);
    tick(5);
    bus_read(ADDR_EVENT, rd);
    check("burst_valid", {31'b0, rd[27]}, 32'h1);
    check("burst_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    last_m = NUM_CH - 1;
    bus_read(ADDR_STATUS, rd);
    check("post_rst_status", rd, status_word(0, 0, 0));
    bus_read(ADDR_CTRL, rd);
    check("post_rst_ctrl", rd, 32'h0);

    // Randomised rounds against the order/timestamp model
    bus_write(ADDR_CTRL, 32'h7);
    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(0, 15));
      det  = 4'($urandom_range(1, 15));
      bus_write(ADDR_CH_MASK, {28'h0, mask});
      pulse(det, k);
      tick(8);
      eff      = det & mask;
      n        = 0;
      new_last = last_m;
      for (int off = 1; off <= NUM_CH; off++) begin
        int ch;
        ch = (last_m + off) % NUM_CH;
        if (eff[ch]) begin
          expq.push_back(exp_entry(ch, k));
          new_last = ch;
          n++;
        end
      end
      last_m = new_last;
      check($sformatf("rnd%0d_irq", r), {31'b0, irq}, {31'b0, n > 0});
      bus_read(ADDR_STATUS, rd);
      check($sformatf("rnd%0d_status", r), rd, status_word(n, 0, 0));
      drain($sformatf("rnd%0d_entry", r));
      bus_read(ADDR_EVENT, rd);
      check($sformatf("rnd%0d_empty", r), rd, 32'h0);
      check($sformatf("rnd%0d_irq_off", r), {31'b0, irq}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
